trap_csr_unit: RTL and testbench

- Machine-mode trap/CSR unit: the consumer end of the hazard unit's trap interface.
- Captures flush-time trap info (cause code, faulting value, PC), updates mepc/mcause/mtval/mstatus and issues a registered redirect to the mtvec base.
- Handles mret return redirect and Zicsr reads and writes from the execute stage.
- Sits beside the writeback stage and feeds the fetch PC mux.

---
 rtl/trap_csr_unit_pkg.sv | 61 ++++++
 rtl/trap_csr_unit_if.sv | 36 +++
 rtl/trap_csr_unit_csr_counter64.sv | 41 ++++
 rtl/trap_csr_unit.sv | 204 ++++++++++++++++++++
 tb/tb_trap_csr_unit.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_csr_unit_pkg.sv
// Shared definitions for the machine-mode trap/CSR unit and its neighbours.
// Holds the CSR operation encoding, CSR addresses, exception cause codes,
// mstatus bit positions and the Zicsr read-modify-write helper.
package trap_csr_unit_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CAUSE_W    = 4;
    localparam int unsigned CSR_ADDR_W = 12;

    // Zicsr operation, low two bits of funct3; CSR_NONE never writes.
    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    // CSR addresses
    localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
    localparam logic [CSR_ADDR_W-1:0] CSR_MISA      = 12'h301;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC     = 12'h305;
    localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [CSR_ADDR_W-1:0] CSR_MEPC      = 12'h341;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE    = 12'h342;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL     = 12'h343;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [CSR_ADDR_W-1:0] CSR_MHARTID   = 12'hF14;

    // Synchronous exception cause codes
    localparam logic [CAUSE_W-1:0] CAUSE_MISALIGNED_FETCH = 4'h0;
    localparam logic [CAUSE_W-1:0] CAUSE_FETCH_FAULT      = 4'h1;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL          = 4'h2;
    localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT       = 4'h3;
    localparam logic [CAUSE_W-1:0] CAUSE_MISALIGNED_LOAD  = 4'h4;
    localparam logic [CAUSE_W-1:0] CAUSE_LOAD_FAULT       = 4'h5;
    localparam logic [CAUSE_W-1:0] CAUSE_MISALIGNED_STORE = 4'h6;
    localparam logic [CAUSE_W-1:0] CAUSE_STORE_FAULT      = 4'h7;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL            = 4'hB;

    // mstatus bit positions
    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MSTATUS_MPP_LO   = 11;
    localparam int unsigned MSTATUS_MPP_HI   = 12;

    // New CSR value for a read-modify-write operation.
    function automatic logic [XLEN-1:0] csr_apply(input csr_op_e op,
                                                  input logic [XLEN-1:0] old_val,
                                                  input logic [XLEN-1:0] data);
        case (op)
            CSR_RW:  return data;
            CSR_RS:  return old_val | data;
            CSR_RC:  return old_val & ~data;
            default: return old_val;
        endcase
    endfunction

endpackage

// File: rtl/trap_csr_unit_if.sv
// Trap/CSR bus between the pipeline (hazard, execute, writeback) and the
// trap/CSR unit.
//   master: pipeline side, drives trap/mret/CSR/retire requests
//   slave : trap/CSR unit, returns read data, illegal flag, redirect, MIE
interface trap_csr_unit_if;
    import trap_csr_unit_pkg::*;

    logic                  trapValid;
    logic [CAUSE_W-1:0]    trapCause;
    logic [XLEN-1:0]       trapValue;
    logic [XLEN-1:0]       trapPc;
    logic                  mretValid;
    logic                  csrValid;
    logic [1:0]            csrOp;
    logic [CSR_ADDR_W-1:0] csrAddress;
    logic [XLEN-1:0]       csrWriteData;
    logic [XLEN-1:0]       csrReadData;
    logic                  csrIllegal;
    logic                  retireValid;
    logic                  redirectValid;
    logic [XLEN-1:0]       redirectPc;
    logic                  interruptEnable;

    modport master (
        output trapValid, trapCause, trapValue, trapPc, mretValid,
               csrValid, csrOp, csrAddress, csrWriteData, retireValid,
        input  csrReadData, csrIllegal, redirectValid, redirectPc, interruptEnable
    );

    modport slave (
        input  trapValid, trapCause, trapValue, trapPc, mretValid,
               csrValid, csrOp, csrAddress, csrWriteData, retireValid,
        output csrReadData, csrIllegal, redirectValid, redirectPc, interruptEnable
    );

endinterface

// File: rtl/trap_csr_unit_csr_counter64.sv
// 64-bit free-running counter with a per-half write port.
//   clock, reset   : clock, synchronous active-low reset (clears to 0)
//   inc_en         : add one this cycle
//   wr_lo, wr_hi   : replace low/high word with wr_data; either blocks inc_en
//   count          : registered counter value
module csr_counter64 (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wr_data,
    output logic [63:0] count
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    // A software write owns the counter for that cycle; no increment.
    always_comb begin
        count_d = count_q;
        if (wr_lo) begin
            count_d[31:0] = wr_data;
        end else if (wr_hi) begin
            count_d[63:32] = wr_data;
        end else if (inc_en) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/trap_csr_unit.sv
// Machine-mode trap/CSR unit: consumer end of the hazard unit's trap path.
// Captures trap info into mepc/mcause/mtval, maintains mstatus.MIE/MPIE,
// serves Zicsr reads/writes from execute and issues a one-cycle registered
// redirect to mtvec (trap) or mepc (mret) for the fetch PC mux.
// Ports:
//   clock, reset : clock, synchronous active-low reset
//   bus (slave)  : trap/mret/CSR/retire requests in; csrReadData and
//                  csrIllegal (combinational), redirectValid/redirectPc and
//                  interruptEnable (registered) out
// Optional feature: define ZICNTR_EN to add the 64-bit mcycle/minstret
// counters; without it the counter addresses read 0 and ignore writes.
module trap_csr_unit
    import trap_csr_unit_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic            clock,
    input  logic            reset,
    trap_csr_unit_if.slave  bus
);

    // Architectural state
    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    // Decode
    csr_op_e         op_c;
    logic [XLEN-1:0] mstatus_rd_c;
    logic [XLEN-1:0] rdata_c;
    logic [XLEN-1:0] wval_c;
    logic            known_c;
    logic            read_only_c;
    logic            has_data_c;
    logic            illegal_c;
    logic            wr_req_c;

`ifdef ZICNTR_EN
    logic [63:0]     mcycle_c;
    logic [63:0]     minstret_c;
`endif

    assign op_c        = csr_op_e'(bus.csrOp);
    assign read_only_c = (bus.csrAddress[11:10] == 2'b11);
    assign has_data_c  = (bus.csrWriteData != '0);

    // mstatus view: only MIE/MPIE are stored, MPP is hardwired to M-mode.
    always_comb begin
        mstatus_rd_c                                  = '0;
        mstatus_rd_c[MSTATUS_MIE_BIT]                 = mie_q;
        mstatus_rd_c[MSTATUS_MPIE_BIT]                = mpie_q;
        mstatus_rd_c[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = 2'b11;
    end

    // Read mux; also flags whether the address is implemented.
    always_comb begin
        known_c = 1'b1;
        rdata_c = '0;
        case (bus.csrAddress)
            CSR_MSTATUS:  rdata_c = mstatus_rd_c;
            CSR_MISA:     rdata_c = MISA_VALUE;
            CSR_MHARTID:  rdata_c = HART_ID;
            CSR_MTVEC:    rdata_c = mtvec_q & ~32'h3;
            CSR_MSCRATCH: rdata_c = mscratch_q;
            CSR_MEPC:     rdata_c = mepc_q;
            CSR_MCAUSE:   rdata_c = mcause_q;
            CSR_MTVAL:    rdata_c = mtval_q;
`ifdef ZICNTR_EN
            CSR_MCYCLE:    rdata_c = mcycle_c[31:0];
            CSR_MCYCLEH:   rdata_c = mcycle_c[63:32];
            CSR_MINSTRET:  rdata_c = minstret_c[31:0];
            CSR_MINSTRETH: rdata_c = minstret_c[63:32];
`else
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: rdata_c = '0;
`endif
            default:      known_c = 1'b0;
        endcase
    end

    // Set/clear with a zero operand is a pure read, so it is legal on
    // read-only CSRs and performs no write.
    assign illegal_c = bus.csrValid &&
                       (!known_c ||
                        (read_only_c && ((op_c == CSR_RW) ||
                                         (((op_c == CSR_RS) || (op_c == CSR_RC)) && has_data_c))));

    assign wr_req_c = bus.csrValid && !illegal_c && !bus.trapValid &&
                      ((op_c == CSR_RW) ||
                       (((op_c == CSR_RS) || (op_c == CSR_RC)) && has_data_c));

    assign wval_c = csr_apply(op_c, rdata_c, bus.csrWriteData);

    // Next state: CSR write first, then mret, then trap overrides.
    always_comb begin
        mie_d            = mie_q;
        mpie_d           = mpie_q;
        mtvec_d          = mtvec_q;
        mscratch_d       = mscratch_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        mtval_d          = mtval_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        // mret owns mstatus and reads mepc/mtvec-side state, so software
        // writes to those are dropped in the same cycle.
        if (wr_req_c) begin
            case (bus.csrAddress)
                CSR_MSTATUS: begin
                    if (!bus.mretValid) begin
                        mie_d  = wval_c[MSTATUS_MIE_BIT];
                        mpie_d = wval_c[MSTATUS_MPIE_BIT];
                    end
                end
                CSR_MTVEC:    if (!bus.mretValid) mtvec_d = wval_c;
                CSR_MEPC:     if (!bus.mretValid) mepc_d = wval_c & ~32'h3;
                CSR_MSCRATCH: mscratch_d = wval_c;
                CSR_MCAUSE:   mcause_d   = wval_c;
                CSR_MTVAL:    mtval_d    = wval_c;
                default: ;
            endcase
        end

        if (bus.trapValid) begin
            mepc_d           = bus.trapPc & ~32'h3;
            mcause_d         = {28'b0, bus.trapCause};
            mtval_d          = bus.trapValue;
            mpie_d           = mie_q;
            mie_d            = 1'b0;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = mtvec_q & ~32'h3;
        end else if (bus.mretValid) begin
            mie_d            = mpie_q;
            mpie_d           = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = mepc_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mie_q            <= 1'b0;
            mpie_q           <= 1'b0;
            mtvec_q          <= RESET_MTVEC;
            mscratch_q       <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mtval_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            mie_q            <= mie_d;
            mpie_q           <= mpie_d;
            mtvec_q          <= mtvec_d;
            mscratch_q       <= mscratch_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            mtval_q          <= mtval_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

`ifdef ZICNTR_EN
    // mcycle ticks every cycle; minstret skips instructions that trapped.
    csr_counter64 u_mcycle (
        .clock   (clock),
        .reset   (reset),
        .inc_en  (1'b1),
        .wr_lo   (wr_req_c && (bus.csrAddress == CSR_MCYCLE)),
        .wr_hi   (wr_req_c && (bus.csrAddress == CSR_MCYCLEH)),
        .wr_data (wval_c),
        .count   (mcycle_c)
    );

    csr_counter64 u_minstret (
        .clock   (clock),
        .reset   (reset),
        .inc_en  (bus.retireValid && !bus.trapValid),
        .wr_lo   (wr_req_c && (bus.csrAddress == CSR_MINSTRET)),
        .wr_hi   (wr_req_c && (bus.csrAddress == CSR_MINSTRETH)),
        .wr_data (wval_c),
        .count   (minstret_c)
    );
`else
    logic unused_retire;
    assign unused_retire = bus.retireValid;
`endif

    assign bus.csrReadData     = bus.csrValid ? rdata_c : '0;
    assign bus.csrIllegal      = illegal_c;
    assign bus.redirectValid   = redirect_valid_q;
    assign bus.redirectPc      = redirect_pc_q;
    assign bus.interruptEnable = mie_q;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Randomised + directed scoreboard bench for trap_csr_unit. The driver
// updates a behavioural CSR model and queues expected read/redirect
// responses; an independent monitor compares them on the falling edge.
module tb_trap_csr_unit;
    import trap_csr_unit_pkg::*;

    localparam logic [31:0] TB_HART = 32'h0000_0003;
    localparam logic [31:0] TB_MISA = 32'h4000_0100;

    logic clock = 1'b0;
    logic reset = 1'b0;

    trap_csr_unit_if bus();

    trap_csr_unit #(
        .RESET_MTVEC (32'h0000_0000),
        .HART_ID     (TB_HART),
        .MISA_VALUE  (TB_MISA)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit mon_on = 1'b0;

    typedef struct {
        logic        rst_n;
        logic        tv;
        logic [3:0]  cause;
        logic [31:0] tval;
        logic [31:0] tpc;
        logic        mret;
        logic        cv;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        retire;
        logic        use_exp;
        logic [31:0] exp;
        logic        exp_ill;
    } stim_t;

    typedef struct {
        int unsigned due;
        logic [31:0] rdata;
        logic        illegal;
        logic        ie;
        logic [11:0] addr;
    } rd_t;

    typedef struct {
        int unsigned due;
        logic [31:0] pc;
    } redir_t;

    rd_t    rd_q[$];
    redir_t redir_q[$];

    // Behavioural model of the architectural CSR state
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic        m_mie, m_mpie;
    logic [63:0] m_cycle, m_instret;

    logic [11:0] addrs [14] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h343, 12'hF14, 12'hB00, 12'hB80,
                                12'hB02, 12'hB82, 12'h7C0, 12'h344};

    function automatic void model_reset();
        m_mtvec = 32'h0; m_mscratch = 32'h0; m_mepc = 32'h0;
        m_mcause = 32'h0; m_mtval = 32'h0;
        m_mie = 1'b0; m_mpie = 1'b0;
        m_cycle = 64'h0; m_instret = 64'h0;
    endfunction

    function automatic void model_read(input logic [11:0] a,
                                       output logic [31:0] v, output logic known);
        known = 1'b1;
        v = 32'h0;
        case (a)
            12'h300: v = 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h301: v = TB_MISA;
            12'hF14: v = TB_HART;
            12'h305: v = m_mtvec & ~32'h3;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
`ifdef ZICNTR_EN
            12'hB00: v = m_cycle[31:0];
            12'hB80: v = m_cycle[63:32];
            12'hB02: v = m_instret[31:0];
            12'hB82: v = m_instret[63:32];
`else
            12'hB00, 12'hB80, 12'hB02, 12'hB82: v = 32'h0;
`endif
            default: known = 1'b0;
        endcase
    endfunction

    function automatic stim_t mk();
        stim_t s;
        s = '{default: '0};
        s.rst_n = 1'b1;
        return s;
    endfunction

    // One clock cycle: drive, queue expectations, advance the model.
    task automatic step(input stim_t s);
        logic [31:0] rv, nv, pre_mtvec, pre_mepc;
        logic        known, illegal, wr, cyc_wr, ins_wr;
        rd_t         e;
        @(posedge clock);
        #1;
        reset            = s.rst_n;
        bus.trapValid    = s.tv;
        bus.trapCause    = s.cause;
        bus.trapValue    = s.tval;
        bus.trapPc       = s.tpc;
        bus.mretValid    = s.mret;
        bus.csrValid     = s.cv;
        bus.csrOp        = s.op;
        bus.csrAddress   = s.addr;
        bus.csrWriteData = s.wdata;
        bus.retireValid  = s.retire;
        if (!s.rst_n) begin
            model_reset();
            return;
        end
        model_read(s.addr, rv, known);
        illegal = s.cv && (!known || ((s.addr[11:10] == 2'b11) &&
                                      (s.op == 2'b01 || s.wdata != 32'h0)));
        if (s.cv) begin
            e.due     = cyc;
            e.rdata   = s.use_exp ? s.exp : (known ? rv : 32'h0);
            e.illegal = s.use_exp ? s.exp_ill : illegal;
            e.ie      = m_mie;
            e.addr    = s.addr;
            rd_q.push_back(e);
        end
        wr = s.cv && !illegal && !s.tv && (s.op == 2'b01 || s.wdata != 32'h0);
        case (s.op)
            2'b01:   nv = s.wdata;
            2'b10:   nv = rv | s.wdata;
            default: nv = rv & ~s.wdata;
        endcase
        pre_mtvec = m_mtvec;
        pre_mepc  = m_mepc;
        cyc_wr = 1'b0;
        ins_wr = 1'b0;
        if (wr) begin
            case (s.addr)
                12'h300: if (!s.mret) begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h305: if (!s.mret) m_mtvec = nv;
                12'h341: if (!s.mret) m_mepc = nv & ~32'h3;
                12'h340: m_mscratch = nv;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
`ifdef ZICNTR_EN
                12'hB00: begin m_cycle[31:0] = nv;    cyc_wr = 1'b1; end
                12'hB80: begin m_cycle[63:32] = nv;   cyc_wr = 1'b1; end
                12'hB02: begin m_instret[31:0] = nv;  ins_wr = 1'b1; end
                12'hB82: begin m_instret[63:32] = nv; ins_wr = 1'b1; end
`endif
                default: ;
            endcase
        end
        if (!cyc_wr) m_cycle = m_cycle + 64'd1;
        if (!ins_wr && s.retire && !s.tv) m_instret = m_instret + 64'd1;
        if (s.tv) begin
            m_mepc   = s.tpc & ~32'h3;
            m_mcause = {28'h0, s.cause};
            m_mtval  = s.tval;
            m_mpie   = m_mie;
            m_mie    = 1'b0;
            redir_q.push_back('{cyc + 1, pre_mtvec & ~32'h3});
        end else if (s.mret) begin
            m_mie  = m_mpie;
            m_mpie = 1'b1;
            redir_q.push_back('{cyc + 1, pre_mepc});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(mk());
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        stim_t s;
        s = mk(); s.cv = 1'b1; s.op = op; s.addr = a; s.wdata = d;
        step(s);
    endtask

    // Access with an explicit constant expectation for read data and illegal.
    task automatic acc_exp(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d,
                           input logic [31:0] exp, input logic exp_ill);
        stim_t s;
        s = mk(); s.cv = 1'b1; s.op = op; s.addr = a; s.wdata = d;
        s.use_exp = 1'b1; s.exp = exp; s.exp_ill = exp_ill;
        step(s);
    endtask

    task automatic rd_exp(input logic [11:0] a, input logic [31:0] exp);
        acc_exp(2'b10, a, 32'h0, exp, 1'b0);
    endtask

    task automatic trap(input logic [3:0] c, input logic [31:0] v, input logic [31:0] pc);
        stim_t s;
        s = mk(); s.tv = 1'b1; s.cause = c; s.tval = v; s.tpc = pc;
        step(s);
    endtask

    // Monitor: redirect and CSR read responses against the queues.
    initial begin
        rd_t    e;
        redir_t r;
        forever begin
            @(negedge clock);
            if (mon_on) begin
                checks++;
                if (redir_q.size() > 0 && redir_q[0].due == cyc) begin
                    r = redir_q.pop_front();
                    if (bus.redirectValid !== 1'b1 || bus.redirectPc !== r.pc) begin
                        errors++;
                        $display("FAIL redirect cyc=%0d: got valid=%b pc=%h, want valid=1 pc=%h",
                                 cyc, bus.redirectValid, bus.redirectPc, r.pc);
                    end
                end else if (bus.redirectValid !== 1'b0) begin
                    errors++;
                    $display("FAIL redirect_idle cyc=%0d: got valid=%b, want 0", cyc, bus.redirectValid);
                end
                checks++;
                if (bus.csrValid === 1'b1) begin
                    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                        e = rd_q.pop_front();
                        if (bus.csrReadData !== e.rdata || bus.csrIllegal !== e.illegal ||
                            bus.interruptEnable !== e.ie) begin
                            errors++;
                            $display("FAIL csr_access cyc=%0d addr=%h: got data=%h ill=%b ie=%b, want data=%h ill=%b ie=%b",
                                     cyc, e.addr, bus.csrReadData, bus.csrIllegal, bus.interruptEnable,
                                     e.rdata, e.illegal, e.ie);
                        end
                    end else begin
                        errors++;
                        $display("FAIL csr_orphan cyc=%0d: got access with no expectation, want queued entry", cyc);
                    end
                end else if (bus.csrReadData !== 32'h0 || bus.csrIllegal !== 1'b0) begin
                    errors++;
                    $display("FAIL csr_idle cyc=%0d: got data=%h ill=%b, want 0/0",
                             cyc, bus.csrReadData, bus.csrIllegal);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        model_reset();
        bus.trapValid = 1'b0; bus.trapCause = '0; bus.trapValue = '0; bus.trapPc = '0;
        bus.mretValid = 1'b0; bus.csrValid = 1'b0; bus.csrOp = '0; bus.csrAddress = '0;
        bus.csrWriteData = '0; bus.retireValid = 1'b0;
        s = mk(); s.rst_n = 1'b0;
        step(s);
        step(s);
        mon_on = 1'b1;

        // Reset values
        rd_exp(12'h305, 32'h0000_0000);
        rd_exp(12'h300, 32'h0000_1800);

        // Trap to software-set mtvec
        csr(2'b01, 12'h305, 32'h8000_0103);
        trap(CAUSE_ILLEGAL, 32'hDEAD_BEEF, 32'h0000_0046);
        rd_exp(12'h341, 32'h0000_0044);
        rd_exp(12'h342, 32'h0000_0002);
        rd_exp(12'h343, 32'hDEAD_BEEF);
        rd_exp(12'h305, 32'h8000_0100);

        // MIE / MPIE through trap and mret
        csr(2'b10, 12'h300, 32'h0000_0008);
        rd_exp(12'h300, 32'h0000_1808);
        trap(CAUSE_ECALL, 32'h0, 32'h0000_0100);
        rd_exp(12'h300, 32'h0000_1880);
        s = mk(); s.mret = 1'b1; step(s);
        rd_exp(12'h300, 32'h0000_1888);

        // Trap + mret + CSR write in one cycle: only the trap lands
        csr(2'b01, 12'h340, 32'h0000_5555);
        s = mk(); s.tv = 1'b1; s.cause = CAUSE_ECALL; s.tpc = 32'h0000_0200;
        s.mret = 1'b1; s.cv = 1'b1; s.op = 2'b01; s.addr = 12'h340; s.wdata = 32'h0000_1234;
        step(s);
        rd_exp(12'h340, 32'h0000_5555);
        rd_exp(12'h341, 32'h0000_0200);

        // mepc write alongside mret is dropped
        s = mk(); s.mret = 1'b1; s.cv = 1'b1; s.op = 2'b01; s.addr = 12'h341; s.wdata = 32'h0000_0998;
        step(s);
        rd_exp(12'h341, 32'h0000_0200);

        // Read-only and unknown addresses
        acc_exp(2'b01, 12'hF14, 32'h0000_0001, TB_HART, 1'b1);
        acc_exp(2'b10, 12'hF14, 32'h0000_0000, TB_HART, 1'b0);
        acc_exp(2'b11, 12'h301, 32'h0000_0000, TB_MISA, 1'b0);
        acc_exp(2'b10, 12'hF14, 32'h0000_0005, TB_HART, 1'b1);
        acc_exp(2'b01, 12'h7C0, 32'h0000_0001, 32'h0, 1'b1);

        // Back-to-back traps
        trap(CAUSE_LOAD_FAULT, 32'h0000_1111, 32'h0000_0300);
        trap(CAUSE_STORE_FAULT, 32'h0000_2222, 32'h0000_0404);
        rd_exp(12'h342, 32'h0000_0007);
        rd_exp(12'h341, 32'h0000_0404);
        rd_exp(12'h343, 32'h0000_2222);
        rd_exp(12'h300, 32'h0000_1800);

        // Reset while a redirect is outstanding
        trap(CAUSE_BREAKPOINT, 32'h0000_3333, 32'h0000_0500);
        s = mk(); s.rst_n = 1'b0; step(s);
        idle(1);
        rd_exp(12'h341, 32'h0000_0000);
        rd_exp(12'h342, 32'h0000_0000);
        rd_exp(12'h305, 32'h0000_0000);

`ifdef ZICNTR_EN
        // Counter half writes and carry
        csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        csr(2'b01, 12'hB80, 32'h0000_0000);
        idle(1);
        rd_exp(12'hB80, 32'h0000_0001);
        csr(2'b01, 12'hB02, 32'h0000_0010);
        csr(2'b01, 12'hB82, 32'h0000_0000);
        s = mk(); s.tv = 1'b1; s.retire = 1'b1; s.tpc = 32'h0000_0600; step(s);
        rd_exp(12'hB02, 32'h0000_0010);
        s = mk(); s.retire = 1'b1; step(s);
        rd_exp(12'hB02, 32'h0000_0011);
`else
        rd_exp(12'hB00, 32'h0000_0000);
        acc_exp(2'b01, 12'hB00, 32'h0000_0123, 32'h0, 1'b0);
        rd_exp(12'hB00, 32'h0000_0000);
`endif

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            s = mk();
            s.tv     = ($urandom_range(0, 9) == 0);
            s.cause  = 4'($urandom_range(0, 15));
            s.tval   = $urandom;
            s.tpc    = $urandom;
            s.mret   = ($urandom_range(0, 9) == 0);
            s.cv     = ($urandom_range(0, 1) == 1);
            s.op     = 2'($urandom_range(1, 3));
            s.addr   = addrs[$urandom_range(0, 13)];
            s.wdata  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            s.retire = ($urandom_range(0, 1) == 1);
            step(s);
        end

        idle(3);
        checks++;
        if (redir_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d redirect and %0d read entries left, want 0 and 0",
                     redir_q.size(), rd_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
